// File: rtl/perf_counter_sched_if.sv
// Event, dump-stream and status signals of the shared performance-counter bank.
// The bench drives the master side; perf_counter_sched sits on the slave side.
interface perf_counter_sched_if #(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 32
);
  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC*2-1:0] evt_inc;
  logic                 dump_req;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [IDX_W-1:0]     dump_idx;
  logic [CNT_W-1:0]     dump_data;
  logic                 dump_done;
  logic                 busy;
  logic [NUM_SRC-1:0]   lost;

  modport master (
    output evt_inc, dump_req, dump_ready,
    input  dump_valid, dump_idx, dump_data, dump_done, busy, lost
  );

  modport slave (
    input  evt_inc, dump_req, dump_ready,
    output dump_valid, dump_idx, dump_data, dump_done, busy, lost
  );
endinterface

// File: rtl/perf_counter_sched.sv
// Saturating per-source pending accumulators folded round-robin into a shared counter bank,
// with a drain-then-stream dump FSM. Optional PERF_CLEAR_ON_DUMP_EN: clear-on-read counters.
module perf_counter_sched #(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 32,
  parameter int PEND_W  = 4
) (
  input logic clk,
  input logic rst,
  perf_counter_sched_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [IDX_W:0]    DRAIN_LOAD = (IDX_W+1)'(NUM_SRC);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_SRC-1);

  typedef enum logic [1:0] {IDLE, DRAIN, STREAM, DONE} stateT;

  stateT              state;
  logic [CNT_W-1:0]   counters [NUM_SRC];
  logic [PEND_W-1:0]  pend     [NUM_SRC];
  logic [PEND_W-1:0]  pendNext [NUM_SRC];
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W:0]     drainCnt;
  logic [IDX_W-1:0]   dumpIdx;
  logic               dumpValid;
  logic               dumpDone;
  logic               busyReg;
  logic [NUM_SRC-1:0] lostReg;
  logic [NUM_SRC-1:0] lostSet;

  logic               schedEn;
  logic               doFold;
  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic [IDX_W-1:0]   cand;
  logic [PEND_W-1:0]  base;
  logic [PEND_W:0]    sum;
  logic               handshake;

  assign schedEn   = (state == IDLE) || (state == DRAIN);
  assign doFold    = schedEn && pickValid;
  assign handshake = dumpValid && bus.dump_ready;

  // Round-robin pick: scanning downward lets the closest non-empty source after rrPtr win.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      cand = rrPtr + IDX_W'(k);
      if (pend[cand] != '0) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  // A folded source restarts from zero but still keeps this cycle's increment.
  always_comb begin
    lostSet = '0;
    base    = '0;
    sum     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      base = (doFold && (pickIdx == IDX_W'(i))) ? '0 : pend[i];
      sum  = {1'b0, base} + (PEND_W+1)'(bus.evt_inc[2*i +: 2]);
      if (sum > {1'b0, PEND_MAX}) begin
        pendNext[i] = PEND_MAX;
        lostSet[i]  = 1'b1;
      end else begin
        pendNext[i] = sum[PEND_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rrPtr     <= '0;
      drainCnt  <= '0;
      dumpIdx   <= '0;
      dumpValid <= 1'b0;
      dumpDone  <= 1'b0;
      busyReg   <= 1'b0;
      lostReg   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        counters[i] <= '0;
        pend[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        pend[i] <= pendNext[i];
      end
      lostReg <= lostReg | lostSet;

      if (doFold) begin
        counters[pickIdx] <= counters[pickIdx] + CNT_W'(pend[pickIdx]);
        rrPtr             <= pickIdx + IDX_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.dump_req) begin
            state    <= DRAIN;
            drainCnt <= DRAIN_LOAD;
            busyReg  <= 1'b1;
          end
        end

        // Folding continues here long enough for every pre-request event to land.
        DRAIN: begin
          if (drainCnt == '0) begin
            state     <= STREAM;
            dumpIdx   <= '0;
            dumpValid <= 1'b1;
          end else begin
            drainCnt <= drainCnt - 1'b1;
          end
        end

        STREAM: begin
          if (handshake) begin
`ifdef PERF_CLEAR_ON_DUMP_EN
            counters[dumpIdx] <= '0;
`endif
            if (dumpIdx == LAST_IDX) begin
              state     <= DONE;
              dumpValid <= 1'b0;
              dumpDone  <= 1'b1;
              dumpIdx   <= '0;
            end else begin
              dumpIdx <= dumpIdx + IDX_W'(1);
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          dumpDone <= 1'b0;
          busyReg  <= 1'b0;
`ifdef PERF_CLEAR_ON_DUMP_EN
          lostReg  <= lostSet;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dump_valid = dumpValid;
  assign bus.dump_idx   = dumpIdx;
  assign bus.dump_data  = counters[dumpIdx];
  assign bus.dump_done  = dumpDone;
  assign bus.busy       = busyReg;
  assign bus.lost       = lostReg;
endmodule

// File: tb/tb_perf_counter_sched.sv
// Directed bench for perf_counter_sched: vector table of single-source scenarios plus
// hand-written saturation, wrap, back-pressure, mid-dump reset and back-to-back sequences.
module tb_perf_counter_sched;
  localparam int NUM_SRC = 8;
  localparam int CNT_W   = 32;
  localparam int SMALL_W = 8;

  typedef logic [CNT_W-1:0]   expArrT   [NUM_SRC];
  typedef logic [SMALL_W-1:0] smallArrT [NUM_SRC];

  typedef struct {
    int               src;
    logic [1:0]       inc;
    int               cycles;
    logic [CNT_W-1:0] expCount;
    logic [NUM_SRC-1:0] expLost;
  } vecT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  perf_counter_sched_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W))   bus();
  perf_counter_sched_if #(.NUM_SRC(NUM_SRC), .CNT_W(SMALL_W)) smallBus();

  // The narrow-counter copy sees identical stimulus so it can show counter wrap cheaply.
  assign smallBus.evt_inc    = bus.evt_inc;
  assign smallBus.dump_req   = bus.dump_req;
  assign smallBus.dump_ready = bus.dump_ready;

  perf_counter_sched #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .PEND_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  perf_counter_sched #(.NUM_SRC(NUM_SRC), .CNT_W(SMALL_W), .PEND_W(4)) smallDut (
    .clk (clk),
    .rst (rst),
    .bus (smallBus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    rst            = 1'b1;
    bus.evt_inc    = '0;
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic postEvents(input int src, input logic [1:0] inc, input int cycles);
    logic [2*NUM_SRC-1:0] v;
    v = '0;
    v[2*src +: 2] = inc;
    bus.evt_inc = v;
    repeat (cycles) @(negedge clk);
    bus.evt_inc = '0;
    repeat (NUM_SRC + 2) @(negedge clk);
  endtask

  task automatic collectDump(output expArrT got, output smallArrT gotSmall);
    int waitCnt;
    for (int b = 0; b < NUM_SRC; b++) begin
      got[b]      = '0;
      gotSmall[b] = '0;
    end
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    checkOutput("busy after dump_req", bus.busy, 1);
    waitCnt = 0;
    while (!bus.dump_valid && waitCnt < 4*NUM_SRC) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("dump_valid arrives", bus.dump_valid, 1);
    if (bus.dump_valid) begin
      for (int b = 0; b < NUM_SRC; b++) begin
        checkOutput($sformatf("beat %0d valid", b), bus.dump_valid, 1);
        checkOutput($sformatf("beat %0d idx", b), bus.dump_idx, 64'(b));
        got[b]      = bus.dump_data;
        gotSmall[b] = smallBus.dump_data;
        bus.dump_ready = 1'b1;
        @(negedge clk);
        bus.dump_ready = 1'b0;
      end
      checkOutput("dump_done after last beat", bus.dump_done, 1);
      checkOutput("valid low in DONE", bus.dump_valid, 0);
      @(negedge clk);
      checkOutput("dump_done single cycle", bus.dump_done, 0);
      checkOutput("busy clears after DONE", bus.busy, 0);
    end
  endtask

  task automatic runDump(input string tag, input expArrT exp);
    expArrT   got;
    smallArrT gotSmall;
    collectDump(got, gotSmall);
    for (int b = 0; b < NUM_SRC; b++) begin
      checkOutput($sformatf("%s data[%0d]", tag, b), got[b], exp[b]);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    expArrT exp;
    resetDut();
    postEvents(v.src, v.inc, v.cycles);
    checkOutput($sformatf("vec src%0d lost", v.src), bus.lost, v.expLost);
    for (int b = 0; b < NUM_SRC; b++) begin
      exp[b] = (b == v.src) ? v.expCount : '0;
    end
    runDump($sformatf("vec src%0d", v.src), exp);
`ifdef PERF_CLEAR_ON_DUMP_EN
    for (int b = 0; b < NUM_SRC; b++) exp[b] = '0;
`endif
    runDump($sformatf("vec src%0d back-to-back", v.src), exp);
  endtask

  initial begin
    vecT      vecs [5];
    expArrT   exp;
    expArrT   got;
    smallArrT gotSmall;
    int       waitCnt;
    int       beats;
    int       extraCnt;

    vecs[0] = '{src: 3, inc: 2'd2, cycles: 5,  expCount: 32'd10, expLost: 8'h00};
    vecs[1] = '{src: 0, inc: 2'd1, cycles: 1,  expCount: 32'd1,  expLost: 8'h00};
    vecs[2] = '{src: 7, inc: 2'd3, cycles: 4,  expCount: 32'd12, expLost: 8'h00};
    vecs[3] = '{src: 5, inc: 2'd3, cycles: 20, expCount: 32'd60, expLost: 8'h00};
    vecs[4] = '{src: 2, inc: 2'd0, cycles: 6,  expCount: 32'd0,  expLost: 8'h00};

    resetDut();
    checkOutput("reset dump_valid", bus.dump_valid, 0);
    checkOutput("reset dump_done", bus.dump_done, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset dump_idx", bus.dump_idx, 0);
    checkOutput("reset lost", bus.lost, 0);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v]);
    end

    // Saturation: every source +3 per cycle, only one fold per cycle.
    resetDut();
    bus.evt_inc = '1;
    repeat (5) @(negedge clk);
    checkOutput("sat lost after 5 cycles", bus.lost, 8'h00);
    @(negedge clk);
    checkOutput("sat lost after 6 cycles", bus.lost, 8'hE0);
    @(negedge clk);
    checkOutput("sat lost after 7 cycles", bus.lost, 8'hE1);
    repeat (13) @(negedge clk);
    bus.evt_inc = '0;
    repeat (NUM_SRC + 2) @(negedge clk);
    checkOutput("sat lost all", bus.lost, 8'hFF);
    collectDump(got, gotSmall);
    for (int b = 0; b < NUM_SRC; b++) begin
      checkOutput($sformatf("sat cnt[%0d] within posted", b), 64'(got[b] <= 60 && got[b] != 0), 1);
    end
`ifdef PERF_CLEAR_ON_DUMP_EN
    checkOutput("sat lost after dump", bus.lost, 8'h00);
`else
    checkOutput("sat lost after dump", bus.lost, 8'hFF);
`endif

    // Wrap: 254 then +3 on source 0; the 8-bit copy must read 1.
    resetDut();
    postEvents(0, 2'd3, 84);
    postEvents(0, 2'd2, 1);
    postEvents(0, 2'd3, 1);
    checkOutput("wrap lost", bus.lost, 0);
    checkOutput("wrap small lost", smallBus.lost, 0);
    collectDump(got, gotSmall);
    checkOutput("wrap wide cnt0", got[0], 257);
    checkOutput("wrap small cnt0", gotSmall[0], 1);
    checkOutput("wrap small cnt1", gotSmall[1], 0);

    // Back-pressure: ready low for 20 cycles, a second request ignored, late events not folded.
    resetDut();
    postEvents(0, 2'd3, 1);
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    waitCnt = 0;
    while (!bus.dump_valid && waitCnt < 4*NUM_SRC) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("stall valid arrives", bus.dump_valid, 1);
    for (int c = 0; c < 20; c++) begin
      checkOutput($sformatf("stall %0d valid", c), bus.dump_valid, 1);
      checkOutput($sformatf("stall %0d idx", c), bus.dump_idx, 0);
      checkOutput($sformatf("stall %0d data", c), bus.dump_data, 3);
      bus.dump_req = (c == 5);
      bus.evt_inc  = (c >= 8 && c < 11) ? 16'h0001 : 16'h0000;
      @(negedge clk);
    end
    bus.dump_req   = 1'b0;
    bus.evt_inc    = '0;
    bus.dump_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 40 && !bus.dump_done; c++) begin
      if (bus.dump_valid) beats++;
      @(negedge clk);
    end
    bus.dump_ready = 1'b0;
    checkOutput("stall beat count", beats, 8);
    checkOutput("stall dump_done seen", bus.dump_done, 1);
    extraCnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.dump_valid || bus.busy) extraCnt++;
    end
    checkOutput("ignored req not queued", extraCnt, 0);

    // Reset in STREAM at idx 4 aborts the dump with no dump_done.
    resetDut();
    postEvents(6, 2'd1, 2);
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    waitCnt = 0;
    while (!bus.dump_valid && waitCnt < 4*NUM_SRC) begin
      @(negedge clk);
      waitCnt++;
    end
    bus.dump_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.dump_ready = 1'b0;
    checkOutput("abort at idx 4", bus.dump_idx, 4);
    checkOutput("abort valid before rst", bus.dump_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort valid", bus.dump_valid, 0);
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort idx", bus.dump_idx, 0);
    checkOutput("abort done", bus.dump_done, 0);
    rst = 1'b0;
    extraCnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.dump_done || bus.dump_valid) extraCnt++;
    end
    checkOutput("abort no late done", extraCnt, 0);
    for (int b = 0; b < NUM_SRC; b++) exp[b] = '0;
    runDump("abort counters", exp);

    // Two dumps around more events on source 1.
    resetDut();
    postEvents(1, 2'd1, 7);
    for (int b = 0; b < NUM_SRC; b++) exp[b] = '0;
    exp[1] = 32'd7;
    runDump("clear first", exp);
    postEvents(1, 2'd1, 2);
`ifdef PERF_CLEAR_ON_DUMP_EN
    exp[1] = 32'd2;
`else
    exp[1] = 32'd9;
`endif
    runDump("clear second", exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
